context_stack_ctrl: RTL
=======================

Name: context_stack_ctrl

Overview:
- Sequencer that implements the `backup` (call) and `restore` (ret) strobes issued by the multicycle control unit.
- On `backup` it copies registers 0..NREG-1 from the register file onto a downward-growing stack in data memory, one word per cycle.
- On `restore` it reads the most recent frame back into the register file.
- While busy it stalls the control unit, and it owns the memory data port for the duration.

Parameters:
- DATA_W, 16, register/memory word width.
- ADDR_W, 16, word-address width.
- NREG, 8, registers saved per frame.
- MAX_DEPTH, 4, maximum nested frames.
- STACK_TOP, 16'hFFFF, reset value of sp (first free slot).

Ports:
- clk  in  1  clock; all state updates on posedge.
- Reset  in  1  reset; synchronous, active-high.
- backup  in  1  save request, level-sampled in IDLE.
- restore  in  1  restore request, level-sampled in IDLE.
- stall  out  1  control unit must hold its state while high.
- reg_rd_idx  out  $clog2(NREG)  register-file read index.
- reg_rd_data  in  DATA_W  combinational read data for reg_rd_idx.
- reg_we  out  1  register-file write enable.
- reg_wr_idx  out  $clog2(NREG)  write index.
- reg_wr_data  out  DATA_W  write data.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write, committed at posedge.
- mem_re  out  1  memory read; mem_rdata valid the following cycle.
- mem_rdata  in  DATA_W  registered read data.
- sp  out  ADDR_W  current stack pointer.
- depth  out  $clog2(MAX_DEPTH+1)  frames currently held.
- err_overflow  out  1  sticky; backup refused.
- err_underflow  out  1  sticky; restore refused.

Behaviour:
- Reset values:
  - state=IDLE, sp=STACK_TOP, depth=0, counter=0.
  - err_* = 0.
  - All strobes (stall, reg_we, mem_we, mem_re) = 0.
  - Data/address outputs = 0.
- States are IDLE, SAVE, LOAD, DRAIN.
- IDLE:
  - backup && depth<MAX_DEPTH -> SAVE, k=0. stall is asserted combinationally in this same cycle.
  - Otherwise restore && depth>0 -> LOAD, k=0, with the same stall rule.
  - backup && restore together: backup wins and restore is dropped.
  - backup with depth==MAX_DEPTH: set err_overflow, stay IDLE, no stall, no memory access.
  - restore with depth==0 (and no backup): set err_underflow, same non-action.
- SAVE, cycle k (0..NREG-1):
  - reg_rd_idx=k, mem_addr=sp, mem_wdata=reg_rd_data, mem_we=1.
  - sp<=sp-1 each cycle.
  - At k==NREG-1: depth<=depth+1, go to IDLE.
  - Total NREG stalled cycles; memory at old_sp-k holds reg k.
- LOAD, cycle k (0..NREG-1):
  - mem_re=1, mem_addr=sp+1, sp<=sp+1.
  - Word read corresponds to reg index NREG-1-k.
  - From k>=1, also writeback of the previous read: reg_we=1, reg_wr_idx=NREG-k, reg_wr_data=mem_rdata.
  - After k==NREG-1 -> DRAIN.
- DRAIN:
  - Final writeback of reg 0; depth<=depth-1; -> IDLE.
  - Total NREG+1 stalled cycles.
- Address arithmetic wraps modulo 2^ADDR_W.
  - Integration requires STACK_TOP - MAX_DEPTH*NREG to stay within data space; no runtime check.
- backup/restore outside IDLE are ignored; the stalled control unit cannot issue them.
- mem_we and mem_re are never high together. reg_we only in LOAD (k>=1) and DRAIN.
- Reset mid-operation aborts immediately. Words already written stay in memory, but sp/depth return to reset values and no further writes occur.
- err_* clear only on Reset.

Decomposition:
- Package `ctx_pkg`: state enum (IDLE/SAVE/LOAD/DRAIN), default widths, STACK_TOP.
- No sub-module. The FSM, counter, sp and depth registers fit in one module.

Test Plan:
- Regs r0..r7 = 16'h1000+i, depth 0, pulse backup -> 8 cycles of stall and mem_we; mem[FFFF-i]=1000+i; sp=FFF7; depth=1.
- Clobber regs to 0, pulse restore -> 9 stall cycles; r7 written first, r0 last; all regs = 1000+i; sp=FFFF; depth=0.
- Nested frames:
  - backup (values A), change regs to B, backup -> sp=FFEF, depth=2.
  - restore -> regs=B.
  - restore -> regs=A, sp=FFFF.
- Overflow/underflow/conflict:
  - 4 backups then a 5th -> err_overflow=1, no mem_we, depth=4.
  - Reset, then restore at depth 0 -> err_underflow=1, stall=0.
  - backup&&restore in IDLE -> SAVE executes.
- Assert Reset at SAVE k=3 -> next cycle stall=0, sp=FFFF, depth=0, no further mem_we.

Source files
------------

// File: rtl/ctx_pkg.sv
// Shared types and default sizing for the context stack sequencer.
package ctx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAVE  = 2'd1,
    LOAD  = 2'd2,
    DRAIN = 2'd3
  } ctx_state_t;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 16;
  localparam int NREG_DEF      = 8;
  localparam int MAX_DEPTH_DEF = 4;
  localparam logic [15:0] STACK_TOP_DEF = 16'hFFFF;

endpackage

// File: rtl/context_stack_ctrl.sv
// Call/return context sequencer: pushes the register file onto a
// downward-growing memory stack on backup and pops it back on restore,
// stalling the control unit and owning the memory port while busy.
module context_stack_ctrl
  import ctx_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NREG      = NREG_DEF,
  parameter int MAX_DEPTH = MAX_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] STACK_TOP = ADDR_W'(STACK_TOP_DEF)
) (
  input  logic                             clk,
  input  logic                             Reset,
  input  logic                             backup,
  input  logic                             restore,
  output logic                             stall,
  output logic [$clog2(NREG)-1:0]          reg_rd_idx,
  input  logic [DATA_W-1:0]                reg_rd_data,
  output logic                             reg_we,
  output logic [$clog2(NREG)-1:0]          reg_wr_idx,
  output logic [DATA_W-1:0]                reg_wr_data,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  output logic                             mem_we,
  output logic                             mem_re,
  input  logic [DATA_W-1:0]                mem_rdata,
  output logic [ADDR_W-1:0]                sp,
  output logic [$clog2(MAX_DEPTH+1)-1:0]   depth,
  output logic                             err_overflow,
  output logic                             err_underflow
);

  localparam int IDX_W = $clog2(NREG);
  localparam int DEP_W = $clog2(MAX_DEPTH+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);

  ctx_state_t        state, state_nx;
  logic [IDX_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] sp_nx;
  logic [DEP_W-1:0]  depth_nx;
  logic              ovf_set, unf_set;

  // State, word counter, stack pointer, depth and sticky error flags.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      sp            <= STACK_TOP;
      depth         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      sp            <= sp_nx;
      depth         <= depth_nx;
      err_overflow  <= err_overflow | ovf_set;
      err_underflow <= err_underflow | unf_set;
    end
  end

  // Next-state decode and per-state port drive; backup beats restore in IDLE.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    sp_nx       = sp;
    depth_nx    = depth;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    stall       = 1'b0;
    reg_rd_idx  = '0;
    reg_we      = 1'b0;
    reg_wr_idx  = '0;
    reg_wr_data = '0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;

    case (state)
      IDLE: begin
        if (backup) begin
          if (depth < DEP_W'(MAX_DEPTH)) begin
            state_nx = SAVE;
            cnt_nx   = '0;
            stall    = 1'b1;
          end else begin
            ovf_set  = 1'b1;
          end
        end else if (restore) begin
          if (depth != '0) begin
            state_nx = LOAD;
            cnt_nx   = '0;
            stall    = 1'b1;
          end else begin
            unf_set  = 1'b1;
          end
        end
      end

      SAVE: begin
        stall      = 1'b1;
        reg_rd_idx = cnt;
        mem_addr   = sp;
        mem_wdata  = reg_rd_data;
        mem_we     = 1'b1;
        sp_nx      = sp - ADDR_W'(1);
        if (cnt == LAST_IDX) begin
          depth_nx = depth + DEP_W'(1);
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx   = cnt + IDX_W'(1);
        end
      end

      LOAD: begin
        stall    = 1'b1;
        mem_re   = 1'b1;
        mem_addr = sp + ADDR_W'(1);
        sp_nx    = sp + ADDR_W'(1);
        if (cnt != '0) begin
          reg_we      = 1'b1;
          reg_wr_idx  = IDX_W'(NREG - int'(cnt));
          reg_wr_data = mem_rdata;
        end
        if (cnt == LAST_IDX) begin
          cnt_nx   = '0;
          state_nx = DRAIN;
        end else begin
          cnt_nx   = cnt + IDX_W'(1);
        end
      end

      DRAIN: begin
        stall       = 1'b1;
        reg_we      = 1'b1;
        reg_wr_idx  = '0;
        reg_wr_data = mem_rdata;
        depth_nx    = depth - DEP_W'(1);
        state_nx    = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
